// File: rtl/tc_counter_pkg.sv
// Shared constants and helpers for the TC step counter family.
package tc_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // All-ones value for a counter of the given width; callers truncate to their width.
    function automatic logic [63:0] reset_limit(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/tc_step_counter_next.sv
// Combinational next-count and boundary-event computation for one count operation.
module tc_step_counter_next
    import tc_counter_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] cur,
    input  logic [BIT_WIDTH-1:0] s,
    input  logic [BIT_WIDTH-1:0] limit,
    input  logic                 dir,
    input  logic                 sat_mode,
    output logic [BIT_WIDTH-1:0] nxt,
    output logic                 boundary
);

    logic [BIT_WIDTH:0]   sum_up;
    logic [BIT_WIDTH-1:0] wrap_up;
    logic [BIT_WIDTH-1:0] wrap_dn;
    logic [BIT_WIDTH-1:0] one;

    assign one    = {{(BIT_WIDTH-1){1'b0}}, 1'b1};
    // The extra bit only matters for the compare; the wrapped results are
    // taken modulo 2^BIT_WIDTH, which equals the truncated wide result.
    assign sum_up  = {1'b0, cur} + {1'b0, s};
    assign wrap_up = cur + s - limit - one;
    assign wrap_dn = cur + limit + one - s;

    always_comb begin
        nxt      = cur;
        boundary = 1'b0;
        if (s != '0) begin
            if (dir == DIR_UP) begin
                if (sum_up > {1'b0, limit}) begin
                    boundary = 1'b1;
                    nxt      = (sat_mode == MODE_SAT) ? limit : wrap_up;
                end else begin
                    nxt = sum_up[BIT_WIDTH-1:0];
                end
            end else begin
                if (cur < s) begin
                    boundary = 1'b1;
                    nxt      = (sat_mode == MODE_SAT) ? '0 : wrap_dn;
                end else begin
                    nxt = cur - s;
                end
            end
        end
    end

endmodule

// File: rtl/tc_step_counter.sv
// Up/down counter with runtime step, programmable limit, wrap/saturate mode,
// terminal-count pulse and sticky overflow flag.
module tc_step_counter
    import tc_counter_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int DEFAULT_STEP = 1,
    parameter int RESET_VALUE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] load_value,
    input  logic                 dir,
    input  logic                 use_step,
    input  logic [BIT_WIDTH-1:0] step,
    input  logic                 sat_mode,
    input  logic                 limit_wr,
    input  logic [BIT_WIDTH-1:0] limit_in,
    input  logic                 clr_ovf,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 tc,
    output logic                 ovf
);

    localparam logic [BIT_WIDTH-1:0] LIMIT_RST = BIT_WIDTH'(reset_limit(BIT_WIDTH));
    localparam logic [BIT_WIDTH-1:0] DSTEP     = BIT_WIDTH'(DEFAULT_STEP);
    localparam logic [BIT_WIDTH-1:0] OUT_RST   = BIT_WIDTH'(RESET_VALUE);

    logic [BIT_WIDTH-1:0] limit;
    logic [BIT_WIDTH-1:0] s_eff;
    logic [BIT_WIDTH-1:0] nxt;
    logic                 boundary;
    logic                 count_evt;

    assign s_eff     = use_step ? step : DSTEP;
    // A boundary only counts when the count operation actually wins priority.
    assign count_evt = en && !load && boundary;

    tc_step_counter_next #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_next (
        .cur      (out),
        .s        (s_eff),
        .limit    (limit),
        .dir      (dir),
        .sat_mode (sat_mode),
        .nxt      (nxt),
        .boundary (boundary)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out   <= OUT_RST;
            limit <= LIMIT_RST;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (limit_wr)
                limit <= limit_in;

            if (load) begin
                out <= load_value;
                tc  <= 1'b0;
            end else if (en) begin
                out <= nxt;
                tc  <= boundary;
            end else begin
                tc  <= 1'b0;
            end

            if (count_evt)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tc_step_counter.sv
// Directed bench for tc_step_counter (BIT_WIDTH=8, DEFAULT_STEP=1, RESET_VALUE=0).
module tb_tc_step_counter;
    import tc_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] load_value;
    logic       dir;
    logic       use_step;
    logic [7:0] step;
    logic       sat_mode;
    logic       limit_wr;
    logic [7:0] limit_in;
    logic       clr_ovf;
    logic [7:0] out;
    logic       tc;
    logic       ovf;

    int n_cmp;
    int n_err;
    logic [8:0] exp_q[$];

    tc_step_counter #(
        .BIT_WIDTH    (8),
        .DEFAULT_STEP (1),
        .RESET_VALUE  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .dir        (dir),
        .use_step   (use_step),
        .step       (step),
        .sat_mode   (sat_mode),
        .limit_wr   (limit_wr),
        .limit_in   (limit_in),
        .clr_ovf    (clr_ovf),
        .out        (out),
        .tc         (tc),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_limit(input logic [7:0] v);
        limit_wr = 1'b1;
        limit_in = v;
        tick();
        limit_wr = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        tick();
        load       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h expected %h", out, 8'h00); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b expected %b", tc, 1'b0); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected %b", ovf, 1'b0); end
        tick();
        rst = 1'b1;
        tick();
        // default limit is 255: 0xFE + 1 stays in range, 0xFF + 1 wraps to 0
        do_load(8'hFE);
        use_step = 1'b0; dir = DIR_UP; sat_mode = MODE_WRAP; en = 1'b1;
        tick();
        n_cmp++; if (out !== 8'hFF) begin n_err++; $display("FAIL rst_limit_fe: got %h expected %h", out, 8'hFF); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL rst_limit_tc0: got %b expected %b", tc, 1'b0); end
        tick();
        n_cmp++; if (out !== 8'h00 || tc !== 1'b1 || ovf !== 1'b1) begin n_err++; $display("FAIL rst_limit_wrap: got out=%h tc=%b ovf=%b expected out=00 tc=1 ovf=1", out, tc, ovf); end
        // count up to 0x20 in steps of 0x10, then reset asynchronously mid-cycle
        use_step = 1'b1; step = 8'h10;
        tick();
        tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'h20 || ovf !== 1'b1) begin n_err++; $display("FAIL count_to_20: got out=%h ovf=%b expected out=20 ovf=1", out, ovf); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (out !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL async_reset: got out=%h tc=%b ovf=%b expected out=00 tc=0 ovf=0", out, tc, ovf); end
        #2 rst = 1'b1;
        use_step = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'h03 || tc !== 1'b0) begin n_err++; $display("FAIL after_reset_count: got out=%h tc=%b expected out=03 tc=0", out, tc); end
    endtask

    task automatic test_wrap_up();
        set_limit(8'd9);
        do_load(8'd8);
        dir = DIR_UP; use_step = 1'b1; step = 8'd3; sat_mode = MODE_WRAP; en = 1'b1;
        tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'd1) begin n_err++; $display("FAIL wrap_up_out: got %0d expected %0d", out, 1); end
        n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL wrap_up_tc: got %b expected %b", tc, 1'b1); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL wrap_up_ovf: got %b expected %b", ovf, 1'b1); end
        tick();
        n_cmp++; if (tc !== 1'b0 || out !== 8'd1) begin n_err++; $display("FAIL wrap_up_pulse_end: got out=%0d tc=%b expected out=1 tc=0", out, tc); end
    endtask

    task automatic test_saturate();
        set_limit(8'd200);
        do_load(8'd198);
        dir = DIR_UP; use_step = 1'b1; step = 8'd5; sat_mode = MODE_SAT; en = 1'b1;
        tick();
        n_cmp++; if (out !== 8'd200 || tc !== 1'b1) begin n_err++; $display("FAIL sat_up_1: got out=%0d tc=%b expected out=200 tc=1", out, tc); end
        tick();
        n_cmp++; if (out !== 8'd200 || tc !== 1'b1) begin n_err++; $display("FAIL sat_up_2: got out=%0d tc=%b expected out=200 tc=1", out, tc); end
        step = 8'd0;
        tick();
        n_cmp++; if (out !== 8'd200 || tc !== 1'b0) begin n_err++; $display("FAIL sat_step0: got out=%0d tc=%b expected out=200 tc=0", out, tc); end
        en = 1'b0;
        do_load(8'd2);
        dir = DIR_DOWN; step = 8'd5; en = 1'b1;
        tick();
        n_cmp++; if (out !== 8'd0 || tc !== 1'b1) begin n_err++; $display("FAIL sat_down_1: got out=%0d tc=%b expected out=0 tc=1", out, tc); end
        tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'd0 || tc !== 1'b1) begin n_err++; $display("FAIL sat_down_2: got out=%0d tc=%b expected out=0 tc=1", out, tc); end
    endtask

    task automatic test_wrap_down();
        set_limit(8'd9);
        do_load(8'd7);
        dir = DIR_DOWN; use_step = 1'b1; step = 8'd3; sat_mode = MODE_WRAP; en = 1'b1;
        tick();
        n_cmp++; if (out !== 8'd4 || tc !== 1'b0) begin n_err++; $display("FAIL down_plain: got out=%0d tc=%b expected out=4 tc=0", out, tc); end
        en = 1'b0;
        do_load(8'd1);
        en = 1'b1;
        tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'd8 || tc !== 1'b1 || ovf !== 1'b1) begin n_err++; $display("FAIL wrap_down: got out=%0d tc=%b ovf=%b expected out=8 tc=1 ovf=1", out, tc, ovf); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_cmp++; if (ovf !== 1'b0 || tc !== 1'b0 || out !== 8'd8) begin n_err++; $display("FAIL clr_ovf: got out=%0d tc=%b ovf=%b expected out=8 tc=0 ovf=0", out, tc, ovf); end
    endtask

    task automatic test_load_priority();
        do_load(8'd8);
        dir = DIR_UP; use_step = 1'b1; step = 8'd3; sat_mode = MODE_WRAP; en = 1'b1;
        tick();
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL pre_load_ovf: got %b expected %b", ovf, 1'b1); end
        load = 1'b1; load_value = 8'h55; clr_ovf = 1'b1;
        tick();
        load = 1'b0; clr_ovf = 1'b0; en = 1'b0;
        n_cmp++; if (out !== 8'h55) begin n_err++; $display("FAIL load_over_en_out: got %h expected %h", out, 8'h55); end
        n_cmp++; if (tc !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL load_over_en_flags: got tc=%b ovf=%b expected tc=0 ovf=0", tc, ovf); end
        // boundary event and clear in the same cycle: set wins
        do_load(8'd8);
        en = 1'b1; clr_ovf = 1'b1;
        tick();
        en = 1'b0; clr_ovf = 1'b0;
        n_cmp++; if (ovf !== 1'b1 || out !== 8'd1) begin n_err++; $display("FAIL set_wins: got out=%0d ovf=%b expected out=1 ovf=1", out, ovf); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic test_default_step();
        set_limit(8'd255);
        do_load(8'd255);
        dir = DIR_UP; use_step = 1'b0; step = 8'd7; sat_mode = MODE_WRAP; en = 1'b1;
        tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'd0 || tc !== 1'b1) begin n_err++; $display("FAIL default_step_wrap: got out=%0d tc=%b expected out=0 tc=1", out, tc); end
        limit_wr = 1'b1; limit_in = 8'd5; load = 1'b1; load_value = 8'h40;
        tick();
        limit_wr = 1'b0; load = 1'b0;
        tick();
        n_cmp++; if (out !== 8'h40 || tc !== 1'b0) begin n_err++; $display("FAIL above_limit_hold: got out=%h tc=%b expected out=40 tc=0", out, tc); end
        en = 1'b1;
        tick();
        en = 1'b0;
        n_cmp++; if (out !== 8'h3B || tc !== 1'b1) begin n_err++; $display("FAIL above_limit_wrap: got out=%h tc=%b expected out=3b tc=1", out, tc); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        set_limit(8'd255);
        do_load(8'd250);
        dir = DIR_UP; use_step = 1'b1; step = 8'd3; sat_mode = MODE_WRAP;
        exp_q.push_back({1'b0, 8'd253});
        exp_q.push_back({1'b1, 8'd0});
        exp_q.push_back({1'b0, 8'd3});
        exp_q.push_back({1'b0, 8'd6});
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = exp_q.pop_front();
            n_cmp++; if ({tc, out} !== exp) begin n_err++; $display("FAIL b2b_cycle%0d: got tc=%b out=%0d expected tc=%b out=%0d", i, tc, out, exp[8], exp[7:0]); end
        end
        en = 1'b0;
        tick();
        n_cmp++; if (out !== 8'd6 || tc !== 1'b0) begin n_err++; $display("FAIL b2b_hold: got out=%0d tc=%b expected out=6 tc=0", out, tc); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; en = 1'b0; load = 1'b0; load_value = '0; dir = DIR_UP;
        use_step = 1'b0; step = '0; sat_mode = MODE_WRAP; limit_wr = 1'b0;
        limit_in = '0; clr_ovf = 1'b0;
        test_reset();
        test_wrap_up();
        test_saturate();
        test_wrap_down();
        test_load_priority();
        test_default_step();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
